// File: rtl/wasm_import_responder.sv
`timescale 1ns/1ps
// wasm_import_responder
//   Host-side servicing of CPU import traps. While the CPU sits halted on an
//   import call, this block latches the call, services putchar / write /
//   get_cycles (write streams guest bytes via the debug memory read port),
//   then resumes the CPU with the return value.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   ext_halted_i          CPU halted on an import (level)
//   import_id_i           import ID, stable while halted
//   import_arg0_i/arg1_i  call arguments
//   resume_pc_i           PC to resume at
//   ext_resume_o          one-cycle resume pulse, with _pc_o / _val_o
//   dbg_mem_rd_*          byte fetch port, data returns one cycle after strobe
//   out_valid_o/data_o    output byte stream, out_ready_i handshake
//   busy_o                FSM not idle
//   unknown_import_o      pulse when an unrecognised ID is serviced
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a halt; latches the call when one is seen
// DISPATCH | decode the latched ID, set up the call
// PUTC     | present the putchar byte until accepted
// RD_REQ   | strobe memory read at ptr + idx
// RD_WAIT  | capture the returned byte
// EMIT     | present the fetched byte until accepted
// RESUME   | one-cycle resume pulse with PC and return value
// RELEASE  | wait for the halt to drop so the same call is not re-serviced

module wasm_import_responder #(
    parameter logic [15:0] ID_PUTCHAR    = 16'd0,
    parameter logic [15:0] ID_WRITE      = 16'd1,
    parameter logic [15:0] ID_CYCLES     = 16'd2,
    parameter int unsigned MAX_WRITE_LEN = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_halted_i,
    input  logic [15:0] import_id_i,
    input  logic [31:0] import_arg0_i,
    input  logic [31:0] import_arg1_i,
    input  logic [31:0] resume_pc_i,
    output logic        ext_resume_o,
    output logic [31:0] ext_resume_pc_o,
    output logic [31:0] ext_resume_val_o,
    output logic        dbg_mem_rd_en_o,
    output logic [31:0] dbg_mem_rd_addr_o,
    input  logic [31:0] dbg_mem_rd_data_i,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        unknown_import_o
);

    localparam int LEN_W = $clog2(MAX_WRITE_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WRITE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_PUTC,
        S_RD_REQ,
        S_RD_WAIT,
        S_EMIT,
        S_RESUME,
        S_RELEASE
    } state_t;

    state_t state, state_d;

    logic [31:0]      cycle_cnt;
    logic [15:0]      id_q;
    logic [31:0]      arg0_q;
    logic [31:0]      arg1_q;
    logic [31:0]      pc_q;
    logic [31:0]      cyc_q;
    logic [31:0]      value_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [7:0]       byte_q;
    logic             last_byte;

    // Only the low byte of each memory word is meaningful.
    logic unused_rd_data;
    assign unused_rd_data = ^dbg_mem_rd_data_i[31:8];

    assign last_byte = (idx_q + LEN_ONE) == len_q;
    assign busy_o    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= '0;
            arg0_q  <= '0;
            arg1_q  <= '0;
            pc_q    <= '0;
            cyc_q   <= '0;
            value_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ext_halted_i) begin
                        id_q   <= import_id_i;
                        arg0_q <= import_arg0_i;
                        arg1_q <= import_arg1_i;
                        pc_q   <= resume_pc_i;
                        cyc_q  <= cycle_cnt;
                    end
                end
                S_DISPATCH: begin
                    idx_q <= '0;
                    case (id_q)
                        ID_PUTCHAR: byte_q <= arg0_q[7:0];
                        ID_WRITE: begin
                            len_q   <= (arg1_q > 32'(MAX_WRITE_LEN)) ? LEN_MAX
                                                                     : arg1_q[LEN_W-1:0];
                            value_q <= '0;
                        end
                        ID_CYCLES: value_q <= cyc_q;
                        default:   value_q <= 32'hFFFF_FFFF;
                    endcase
                end
                S_PUTC: begin
                    if (out_ready_i) begin
                        value_q <= '0;
                    end
                end
                S_RD_WAIT: byte_q <= dbg_mem_rd_data_i[7:0];
                S_EMIT: begin
                    if (out_ready_i) begin
                        idx_q   <= idx_q + LEN_ONE;
                        value_q <= 32'(len_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d           = state;
        ext_resume_o      = 1'b0;
        ext_resume_pc_o   = '0;
        ext_resume_val_o  = '0;
        dbg_mem_rd_en_o   = 1'b0;
        dbg_mem_rd_addr_o = '0;
        out_valid_o       = 1'b0;
        out_data_o        = '0;
        unknown_import_o  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ext_halted_i) begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                case (id_q)
                    ID_PUTCHAR: state_d = S_PUTC;
                    ID_WRITE:   state_d = (arg1_q == '0) ? S_RESUME : S_RD_REQ;
                    ID_CYCLES:  state_d = S_RESUME;
                    default: begin
                        unknown_import_o = 1'b1;
                        state_d          = S_RESUME;
                    end
                endcase
            end
            S_PUTC: begin
                out_valid_o = 1'b1;
                out_data_o  = byte_q;
                if (out_ready_i) begin
                    state_d = S_RESUME;
                end
            end
            S_RD_REQ: begin
                dbg_mem_rd_en_o   = 1'b1;
                dbg_mem_rd_addr_o = arg0_q + 32'(idx_q);
                state_d           = S_RD_WAIT;
            end
            S_RD_WAIT: state_d = S_EMIT;
            S_EMIT: begin
                out_valid_o = 1'b1;
                out_data_o  = byte_q;
                if (out_ready_i) begin
                    state_d = last_byte ? S_RESUME : S_RD_REQ;
                end
            end
            S_RESUME: begin
                ext_resume_o     = 1'b1;
                ext_resume_pc_o  = pc_q;
                ext_resume_val_o = value_q;
                state_d          = S_RELEASE;
            end
            S_RELEASE: begin
                if (!ext_halted_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
